// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset vector, NOP encoding
// and the fetch FSM state encoding.
package cpu_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef logic [0:0] fetch_state_t;
   localparam fetch_state_t FETCH = 1'b0;
   localparam fetch_state_t DRAIN = 1'b1;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush and occupancy count; the head entry is
// visible combinationally on rdata.
module fetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign rdata = mem[rd_ptr];

   // Storage carries no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Callers size their traffic so these can never fire.
   always_ff @(posedge clk) begin
      if (rst_n && !flush) begin
         assert (!(push && !pop && count == FULL_COUNT));
         assert (!(pop && count == '0));
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order reads to
// RAM, queues returned words for decode and flushes on branch/jump redirect.
module fetch_unit #(
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter int              QDEPTH   = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc
);

   import cpu_pkg::*;

   localparam int          CW      = $clog2(QDEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(QDEPTH);

   logic [XLEN-1:0]   pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     out_next;
   logic [CW-1:0]     drop_dec;
   logic [CW-1:0]     q_count;
   logic [CW-1:0]     pcq_count;
   logic [CW:0]       credit_used;
   fetch_state_t      state;
   logic              run;
   logic              accept;
   logic              rsp_live;
   logic              pop;
   logic [XLEN-1:0]   pcq_head;
   logic [2*XLEN-1:0] q_rdata;
   logic              unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Every read in flight owns a queue slot, so the queue can never overflow.
   assign credit_used   = {1'b0, outstanding} + {1'b0, q_count};
   assign mem_req_valid = run && (state == FETCH) && (credit_used < CREDITS);
   assign mem_req_addr  = pc;
   assign accept        = mem_req_valid && mem_req_ready;

   assign rsp_live = mem_rsp_valid && (drop == '0) && !redirect_valid;
   assign pop      = inst_valid && inst_ready && !redirect_valid;
   assign out_next = outstanding + CW'(accept) - CW'(mem_rsp_valid);
   assign drop_dec = (mem_rsp_valid && drop != '0) ? drop - CW'(1) : drop;

   assign inst_valid = (q_count != '0);
   assign inst_data  = inst_valid ? q_rdata[2*XLEN-1:XLEN] : '0;
   assign inst_pc    = inst_valid ? q_rdata[XLEN-1:0]      : '0;

   // A redirect turns everything still in flight into reads to be discarded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         state       <= FETCH;
         outstanding <= '0;
         drop        <= '0;
         run         <= 1'b0;
      end else begin
         run         <= 1'b1;
         outstanding <= out_next;
         if (redirect_valid) begin
            pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            drop  <= out_next;
            state <= (out_next == '0) ? FETCH : DRAIN;
         end else begin
            if (accept) begin
               pc <= pc + XLEN'(4);
            end
            drop <= drop_dec;
            if (state == DRAIN && drop_dec == '0) begin
               state <= FETCH;
            end
         end
      end
   end

   fetch_queue #(
      .WIDTH (2*XLEN),
      .DEPTH (QDEPTH)
   ) u_inst_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (rsp_live),
      .wdata ({mem_rsp_data, pcq_head}),
      .pop   (pop),
      .rdata (q_rdata),
      .count (q_count)
   );

   // Remembers the address of each live read so its response can be tagged.
   fetch_queue #(
      .WIDTH (XLEN),
      .DEPTH (QDEPTH)
   ) u_pc_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (accept && !redirect_valid),
      .wdata (pc),
      .pop   (rsp_live),
      .rdata (pcq_head),
      .count (pcq_count)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (drop != '0 || pcq_count == outstanding);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a fixed-latency in-order
// RAM model whose read data is {16'hC0DE, addr[15:0]}.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int checks   = 0;
   int failures = 0;

   logic [2:0]  lat_idx = 3'd0;
   logic        pv [8];
   logic [31:0] pa [8];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   // RAM model: a delay line of accepted addresses, tapped at the latency.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
      end else begin
         pv[0] <= mem_req_valid && mem_req_ready;
         pa[0] <= mem_req_addr;
         for (int i = 1; i < 8; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
      end
   end

   assign mem_rsp_valid = pv[lat_idx];
   assign mem_rsp_data  = {16'hC0DE, pa[lat_idx][15:0]};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat);
      rst_n          = 1'b0;
      mem_req_ready  = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b1;
      lat_idx        = 3'(lat - 1);
      step();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1);
      rst_n = 1'b0;
      step();
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_req_addr got=%h exp=00000000", mem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_valid got=%b exp=0", inst_valid); end
      checks++; if (inst_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_data got=%h exp=00000000", inst_data); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst_pc got=%h exp=00000000", inst_pc); end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      do_reset(1);
      for (int k = 0; k < 6; k++) begin
         step();
         checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_req_valid k=%0d got=%b exp=1", k, mem_req_valid); end
         checks++; if (mem_req_addr !== 32'(4*k)) begin failures++; $display("[TB] FAIL stream_addr k=%0d got=%h exp=%h", k, mem_req_addr, 32'(4*k)); end
         checks++; if (inst_valid !== (k >= 2)) begin failures++; $display("[TB] FAIL stream_inst_valid k=%0d got=%b exp=%b", k, inst_valid, (k >= 2)); end
         if (k >= 2) begin
            e = 32'(4*(k-2));
            checks++; if (inst_pc !== e) begin failures++; $display("[TB] FAIL stream_pc k=%0d got=%h exp=%h", k, inst_pc, e); end
            checks++; if (inst_data !== {16'hC0DE, e[15:0]}) begin failures++; $display("[TB] FAIL stream_data k=%0d got=%h exp=%h", k, inst_data, {16'hC0DE, e[15:0]}); end
         end
      end
   endtask

   task automatic test_backpressure();
      int n_acc = 0;
      int got   = 0;
      logic [31:0] e;
      do_reset(1);
      inst_ready = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (mem_req_valid && mem_req_ready) n_acc++;
         step();
      end
      checks++; if (n_acc !== 4) begin failures++; $display("[TB] FAIL stall_accepts got=%0d exp=4", n_acc); end
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_valid got=%b exp=0", mem_req_valid); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL stall_head got=%b/%h exp=1/00000000", inst_valid, inst_pc); end
      inst_ready = 1'b1;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (inst_valid && inst_ready) begin
            e = 32'(4*got);
            checks++; if (inst_pc !== e || inst_data !== {16'hC0DE, e[15:0]}) begin failures++; $display("[TB] FAIL resume_order n=%0d got=%h/%h exp=%h/%h", got, inst_pc, inst_data, e, {16'hC0DE, e[15:0]}); end
            got++;
         end
         step();
      end
      checks++; if (got !== 8) begin failures++; $display("[TB] FAIL resume_count got=%0d exp=8", got); end
   endtask

   task automatic test_redirect_drain();
      int got = 0;
      logic [31:0] e;
      do_reset(3);
      step(); step(); step(); step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_quiet k=%0d got=%b/%b exp=0/0", k, mem_req_valid, inst_valid); end
         step();
      end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin failures++; $display("[TB] FAIL drain_restart got=%b/%h exp=1/00000100", mem_req_valid, mem_req_addr); end
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (inst_valid && inst_ready) begin
            e = 32'h100 + 32'(4*got);
            checks++; if (inst_pc !== e || inst_data !== {16'hC0DE, e[15:0]}) begin failures++; $display("[TB] FAIL drain_seq n=%0d got=%h/%h exp=%h/%h", got, inst_pc, inst_data, e, {16'hC0DE, e[15:0]}); end
            got++;
         end
         step();
      end
      checks++; if (got !== 2) begin failures++; $display("[TB] FAIL drain_seq_count got=%0d exp=2", got); end
   endtask

   task automatic test_redirect_idle();
      int got = 0;
      logic [31:0] e;
      do_reset(1);
      mem_req_ready = 1'b0;
      step();
      step();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL idle_addr_stable got=%b/%h exp=1/00000000", mem_req_valid, mem_req_addr); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      step();
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin failures++; $display("[TB] FAIL idle_redirect got=%b/%h exp=1/00000200", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (inst_valid && inst_ready) begin
            e = 32'h200 + 32'(4*got);
            checks++; if (inst_pc !== e) begin failures++; $display("[TB] FAIL idle_seq n=%0d got=%h exp=%h", got, inst_pc, e); end
            got++;
         end
         step();
      end
      checks++; if (got !== 2) begin failures++; $display("[TB] FAIL idle_seq_count got=%0d exp=2", got); end
   endtask

   task automatic test_redirect_accept();
      bit seen = 1'b0;
      do_reset(2);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      step();
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h300) begin failures++; $display("[TB] FAIL acc_drain got=%b/%h exp=0/00000300", mem_req_valid, mem_req_addr); end
      for (int c = 0; c < 20 && !seen; c++) begin
         if (inst_valid) begin
            seen = 1'b1;
            checks++; if (inst_pc !== 32'h300 || inst_data !== 32'hC0DE_0300) begin failures++; $display("[TB] FAIL acc_first got=%h/%h exp=00000300/c0de0300", inst_pc, inst_data); end
         end
         step();
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL acc_timeout got=0 exp=1"); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset(1);
      mem_req_ready = 1'b0;
      inst_ready    = 1'b0;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_top got=%b/%h exp=1/fffffffc", mem_req_valid, mem_req_addr); end
      mem_req_ready = 1'b1;
      step();
      checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr got=%h exp=00000000", mem_req_addr); end
      step();
      step();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'hC0DE_FFFC) begin failures++; $display("[TB] FAIL wrap_inst got=%b/%h/%h exp=1/fffffffc/c0defffc", inst_valid, inst_pc, inst_data); end
      rst_n = 1'b0;
      step();
      checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL midreset_req got=%b/%h exp=0/00000000", mem_req_valid, mem_req_addr); end
      checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL midreset_inst got=%b/%h/%h exp=0/00000000/00000000", inst_valid, inst_data, inst_pc); end
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drain();
      test_redirect_idle();
      test_redirect_accept();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
